// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS controller: opcodes, FSM state
// encodings, datapath mux/ALU codes and the packed control word.
// No ports; imported by mips_multicycle_controller and mc_output_decode.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEX   = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11,
    S_TRAP     = 4'd12
  } state_t;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  typedef struct packed {
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       pcwrite;
    logic       branch;
    logic       branch_ne;
    logic [1:0] pcsrc;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic       regwrite;
    logic       memtoreg;
    logic       regdst;
    logic       illegal_op;
  } ctrl_t;

endpackage

// File: rtl/mc_output_decode.sv
// Purpose: combinational state -> control word lookup for the multicycle FSM.
// Latency: zero (pure combinational). Backpressure: FETCH strobes follow i_mem_rdy.
// Ports: i_state (current state), i_mem_rdy (effective memory ready),
//        i_is_bne (latched bne flag for BRANCH), o_ctrl (control word).
module mc_output_decode
  import mips_pkg::*;
(
  input  state_t i_state,
  input  logic   i_mem_rdy,
  input  logic   i_is_bne,
  output ctrl_t  o_ctrl
);

  always_comb begin
    o_ctrl = '0;
    case (i_state)
      S_FETCH: begin
        o_ctrl.alusrcb = SRCB_FOUR;
        // IR and PC load only on the cycle the fetch completes.
        o_ctrl.irwrite = i_mem_rdy;
        o_ctrl.pcwrite = i_mem_rdy;
      end
      S_DECODE: o_ctrl.alusrcb = SRCB_IMMSH;
      S_MEMADR: begin
        o_ctrl.alusrca = 1'b1;
        o_ctrl.alusrcb = SRCB_IMM;
      end
      S_MEMREAD: o_ctrl.iord = 1'b1;
      S_MEMWB: begin
        o_ctrl.regwrite = 1'b1;
        o_ctrl.memtoreg = 1'b1;
      end
      S_MEMWRITE: begin
        // Strobe held across the whole stall so the slave sees it on its ready cycle.
        o_ctrl.iord     = 1'b1;
        o_ctrl.memwrite = 1'b1;
      end
      S_EXECUTE: begin
        o_ctrl.alusrca = 1'b1;
        o_ctrl.aluop   = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        o_ctrl.regdst   = 1'b1;
        o_ctrl.regwrite = 1'b1;
      end
      S_BRANCH: begin
        o_ctrl.alusrca   = 1'b1;
        o_ctrl.aluop     = ALUOP_SUB;
        o_ctrl.pcsrc     = PCSRC_ALUOUT;
        o_ctrl.branch    = !i_is_bne;
        o_ctrl.branch_ne = i_is_bne;
      end
      S_ADDIEX: begin
        o_ctrl.alusrca = 1'b1;
        o_ctrl.alusrcb = SRCB_IMM;
      end
      S_ADDIWB: o_ctrl.regwrite = 1'b1;
      S_JUMP: begin
        o_ctrl.pcsrc   = PCSRC_JUMP;
        o_ctrl.pcwrite = 1'b1;
      end
      S_TRAP: o_ctrl.illegal_op = 1'b1;
      default: o_ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_controller.sv
// Purpose: Moore control FSM sequencing multicycle MIPS instructions.
// Latency: lw 5, sw/R/addi 4, beq/bne/j 3 cycles; +1 per memory wait cycle.
// Backpressure: FETCH/MEMREAD/MEMWRITE stall while mem_ready is low (MEM_WAIT=1).
// Ports: clk, reset (async high), op (IR opcode), mem_ready, and the datapath
//        control outputs iord..regdst plus the sticky illegal_op trap flag.
module mips_multicycle_controller
  import mips_pkg::*;
#(
  parameter int OP_W        = 6,
  parameter int SUPPORT_BNE = 0,
  parameter int MEM_WAIT    = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [OP_W-1:0] op,
  input  logic            mem_ready,
  output logic            iord,
  output logic            memwrite,
  output logic            irwrite,
  output logic            pcwrite,
  output logic            branch,
  output logic            branch_ne,
  output logic [1:0]      pcsrc,
  output logic            alusrca,
  output logic [1:0]      alusrcb,
  output logic [1:0]      aluop,
  output logic            regwrite,
  output logic            memtoreg,
  output logic            regdst,
  output logic            illegal_op
);

  state_t r_state;
  state_t w_next;
  logic   r_is_bne;
  logic   w_rdy;
  logic   w_op_lw, w_op_sw, w_op_rtype, w_op_beq, w_op_bne, w_op_addi, w_op_j;
  ctrl_t  w_ctrl;
  ctrl_t  w_ctrl_g;

  assign w_rdy      = (MEM_WAIT == 0) ? 1'b1 : mem_ready;
  assign w_op_lw    = (op == OP_W'(OP_LW));
  assign w_op_sw    = (op == OP_W'(OP_SW));
  assign w_op_rtype = (op == OP_W'(OP_RTYPE));
  assign w_op_beq   = (op == OP_W'(OP_BEQ));
  // bne is only decoded when the build enables it; otherwise it falls to TRAP.
  assign w_op_bne   = (SUPPORT_BNE != 0) && (op == OP_W'(OP_BNE));
  assign w_op_addi  = (op == OP_W'(OP_ADDI));
  assign w_op_j     = (op == OP_W'(OP_J));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_FETCH;
      r_is_bne <= 1'b0;
    end else begin
      r_state <= w_next;
      // Branch flavour is captured at decode so BRANCH stays a pure state output.
      if (r_state == S_DECODE) r_is_bne <= w_op_bne;
    end
  end

  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:    w_next = w_rdy ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if (w_op_lw || w_op_sw)       w_next = S_MEMADR;
        else if (w_op_rtype)          w_next = S_EXECUTE;
        else if (w_op_beq || w_op_bne) w_next = S_BRANCH;
        else if (w_op_addi)           w_next = S_ADDIEX;
        else if (w_op_j)              w_next = S_JUMP;
        else                          w_next = S_TRAP;
      end
      S_MEMADR:   w_next = w_op_lw ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  w_next = w_rdy ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    w_next = S_FETCH;
      S_MEMWRITE: w_next = w_rdy ? S_FETCH : S_MEMWRITE;
      S_EXECUTE:  w_next = S_ALUWB;
      S_ALUWB:    w_next = S_FETCH;
      S_BRANCH:   w_next = S_FETCH;
      S_ADDIEX:   w_next = S_ADDIWB;
      S_ADDIWB:   w_next = S_FETCH;
      S_JUMP:     w_next = S_FETCH;
      S_TRAP:     w_next = S_TRAP;
      default:    w_next = S_FETCH;
    endcase
  end

  mc_output_decode u_decode (
    .i_state   (r_state),
    .i_mem_rdy (w_rdy),
    .i_is_bne  (r_is_bne),
    .o_ctrl    (w_ctrl)
  );

  // Reset silences every output at once, including the FETCH strobes.
  assign w_ctrl_g = reset ? '0 : w_ctrl;

  assign iord       = w_ctrl_g.iord;
  assign memwrite   = w_ctrl_g.memwrite;
  assign irwrite    = w_ctrl_g.irwrite;
  assign pcwrite    = w_ctrl_g.pcwrite;
  assign branch     = w_ctrl_g.branch;
  assign branch_ne  = w_ctrl_g.branch_ne;
  assign pcsrc      = w_ctrl_g.pcsrc;
  assign alusrca    = w_ctrl_g.alusrca;
  assign alusrcb    = w_ctrl_g.alusrcb;
  assign aluop      = w_ctrl_g.aluop;
  assign regwrite   = w_ctrl_g.regwrite;
  assign memtoreg   = w_ctrl_g.memtoreg;
  assign regdst     = w_ctrl_g.regdst;
  assign illegal_op = w_ctrl_g.illegal_op;

endmodule

// File: tb/tb_mips_multicycle_controller.sv
// Directed, table-driven bench for mips_multicycle_controller.
// Instance a: SUPPORT_BNE=1, MEM_WAIT=1. Instance b: SUPPORT_BNE=0, MEM_WAIT=0.
// Output word order: iord memwrite irwrite pcwrite branch branch_ne pcsrc[2]
//                    alusrca alusrcb[2] aluop[2] regwrite memtoreg regdst illegal_op
module tb_mips_multicycle_controller;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] BEQ = 6'b000100, BNE = 6'b000101, ADDI = 6'b001000;
  localparam logic [5:0] J = 6'b000010, BAD = 6'b111111;

  localparam logic [16:0] E_ZERO = 17'b0_0_0_0_0_0_00_0_00_00_0_0_0_0;
  localparam logic [16:0] E_FR   = 17'b0_0_1_1_0_0_00_0_01_00_0_0_0_0;
  localparam logic [16:0] E_FW   = 17'b0_0_0_0_0_0_00_0_01_00_0_0_0_0;
  localparam logic [16:0] E_DEC  = 17'b0_0_0_0_0_0_00_0_11_00_0_0_0_0;
  localparam logic [16:0] E_MA   = 17'b0_0_0_0_0_0_00_1_10_00_0_0_0_0;
  localparam logic [16:0] E_MR   = 17'b1_0_0_0_0_0_00_0_00_00_0_0_0_0;
  localparam logic [16:0] E_MWB  = 17'b0_0_0_0_0_0_00_0_00_00_1_1_0_0;
  localparam logic [16:0] E_MW   = 17'b1_1_0_0_0_0_00_0_00_00_0_0_0_0;
  localparam logic [16:0] E_EX   = 17'b0_0_0_0_0_0_00_1_00_10_0_0_0_0;
  localparam logic [16:0] E_AWB  = 17'b0_0_0_0_0_0_00_0_00_00_1_0_1_0;
  localparam logic [16:0] E_BEQ  = 17'b0_0_0_0_1_0_01_1_00_01_0_0_0_0;
  localparam logic [16:0] E_BNE  = 17'b0_0_0_0_0_1_01_1_00_01_0_0_0_0;
  localparam logic [16:0] E_AIWB = 17'b0_0_0_0_0_0_00_0_00_00_1_0_0_0;
  localparam logic [16:0] E_JMP  = 17'b0_0_0_1_0_0_10_0_00_00_0_0_0_0;
  localparam logic [16:0] E_TRAP = 17'b0_0_0_0_0_0_00_0_00_00_0_0_0_1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       a_rst = 1'b1, a_rdy = 1'b1;
  logic [5:0] a_op = 6'd0;
  logic       a_iord, a_memwrite, a_irwrite, a_pcwrite, a_branch, a_branch_ne;
  logic       a_alusrca, a_regwrite, a_memtoreg, a_regdst, a_illegal;
  logic [1:0] a_pcsrc, a_alusrcb, a_aluop;
  logic [16:0] a_out;

  logic       b_rst = 1'b1, b_rdy = 1'b1;
  logic [5:0] b_op = 6'd0;
  logic       b_iord, b_memwrite, b_irwrite, b_pcwrite, b_branch, b_branch_ne;
  logic       b_alusrca, b_regwrite, b_memtoreg, b_regdst, b_illegal;
  logic [1:0] b_pcsrc, b_alusrcb, b_aluop;
  logic [16:0] b_out;

  assign a_out = {a_iord, a_memwrite, a_irwrite, a_pcwrite, a_branch, a_branch_ne, a_pcsrc,
                  a_alusrca, a_alusrcb, a_aluop, a_regwrite, a_memtoreg, a_regdst, a_illegal};
  assign b_out = {b_iord, b_memwrite, b_irwrite, b_pcwrite, b_branch, b_branch_ne, b_pcsrc,
                  b_alusrca, b_alusrcb, b_aluop, b_regwrite, b_memtoreg, b_regdst, b_illegal};

  mips_multicycle_controller #(.OP_W(6), .SUPPORT_BNE(1), .MEM_WAIT(1)) dut_a (
    .clk(clk), .reset(a_rst), .op(a_op), .mem_ready(a_rdy),
    .iord(a_iord), .memwrite(a_memwrite), .irwrite(a_irwrite), .pcwrite(a_pcwrite),
    .branch(a_branch), .branch_ne(a_branch_ne), .pcsrc(a_pcsrc), .alusrca(a_alusrca),
    .alusrcb(a_alusrcb), .aluop(a_aluop), .regwrite(a_regwrite), .memtoreg(a_memtoreg),
    .regdst(a_regdst), .illegal_op(a_illegal)
  );

  mips_multicycle_controller #(.OP_W(6), .SUPPORT_BNE(0), .MEM_WAIT(0)) dut_b (
    .clk(clk), .reset(b_rst), .op(b_op), .mem_ready(b_rdy),
    .iord(b_iord), .memwrite(b_memwrite), .irwrite(b_irwrite), .pcwrite(b_pcwrite),
    .branch(b_branch), .branch_ne(b_branch_ne), .pcsrc(b_pcsrc), .alusrca(b_alusrca),
    .alusrcb(b_alusrcb), .aluop(b_aluop), .regwrite(b_regwrite), .memtoreg(b_memtoreg),
    .regdst(b_regdst), .illegal_op(b_illegal)
  );

  typedef struct packed {
    logic        sel;   // 0 = dut_a, 1 = dut_b
    logic        rst;
    logic [5:0]  op;
    logic        rdy;
    logic [16:0] exp;
  } vec_t;

  vec_t vecs[$];
  int total = 0;
  int bad   = 0;

  function automatic vec_t mk(input logic s, input logic r, input logic [5:0] o,
                              input logic rd, input logic [16:0] e);
    vec_t v;
    v.sel = s; v.rst = r; v.op = o; v.rdy = rd; v.exp = e;
    return v;
  endfunction

  task automatic check(input string name, input logic [16:0] act, input logic [16:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  // One vector = one clock cycle: drive at negedge, compare 1 ns later.
  task automatic apply(input vec_t v, input int idx);
    @(negedge clk);
    if (v.sel == 1'b0) begin
      a_rst = v.rst; a_op = v.op; a_rdy = v.rdy;
    end else begin
      b_rst = v.rst; b_op = v.op; b_rdy = v.rdy;
    end
    #1;
    check($sformatf("vec%0d_%s", idx, v.sel ? "b" : "a"), v.sel ? b_out : a_out, v.exp);
  endtask

  initial begin
    int mw_cnt;
    logic rw_seen;

    // dut_a: reset, lw with no wait (5 cycles)
    vecs.push_back(mk(0, 1, RT, 1, E_ZERO));
    vecs.push_back(mk(0, 0, LW, 1, E_FR));
    vecs.push_back(mk(0, 0, LW, 1, E_DEC));
    vecs.push_back(mk(0, 0, LW, 1, E_MA));
    vecs.push_back(mk(0, 0, LW, 1, E_MR));
    vecs.push_back(mk(0, 0, LW, 1, E_MWB));
    // sw with three MEMWRITE wait cycles, then a fetch wait
    vecs.push_back(mk(0, 0, SW, 1, E_FR));
    vecs.push_back(mk(0, 0, SW, 1, E_DEC));
    vecs.push_back(mk(0, 0, SW, 1, E_MA));
    vecs.push_back(mk(0, 0, SW, 0, E_MW));
    vecs.push_back(mk(0, 0, SW, 0, E_MW));
    vecs.push_back(mk(0, 0, SW, 0, E_MW));
    vecs.push_back(mk(0, 0, SW, 1, E_MW));
    vecs.push_back(mk(0, 0, RT, 0, E_FW));
    // R-type; op garbage during EXECUTE/ALUWB must be ignored
    vecs.push_back(mk(0, 0, RT, 1, E_FR));
    vecs.push_back(mk(0, 0, RT, 1, E_DEC));
    vecs.push_back(mk(0, 0, BAD, 1, E_EX));
    vecs.push_back(mk(0, 0, BAD, 1, E_AWB));
    // beq then bne
    vecs.push_back(mk(0, 0, BEQ, 1, E_FR));
    vecs.push_back(mk(0, 0, BEQ, 1, E_DEC));
    vecs.push_back(mk(0, 0, BEQ, 1, E_BEQ));
    vecs.push_back(mk(0, 0, BNE, 1, E_FR));
    vecs.push_back(mk(0, 0, BNE, 1, E_DEC));
    vecs.push_back(mk(0, 0, BNE, 1, E_BNE));
    // addi
    vecs.push_back(mk(0, 0, ADDI, 1, E_FR));
    vecs.push_back(mk(0, 0, ADDI, 1, E_DEC));
    vecs.push_back(mk(0, 0, ADDI, 1, E_MA));
    vecs.push_back(mk(0, 0, ADDI, 1, E_AIWB));
    // j
    vecs.push_back(mk(0, 0, J, 1, E_FR));
    vecs.push_back(mk(0, 0, J, 1, E_DEC));
    vecs.push_back(mk(0, 0, J, 1, E_JMP));
    // lw with two MEMREAD wait cycles
    vecs.push_back(mk(0, 0, LW, 1, E_FR));
    vecs.push_back(mk(0, 0, LW, 1, E_DEC));
    vecs.push_back(mk(0, 0, LW, 1, E_MA));
    vecs.push_back(mk(0, 0, LW, 0, E_MR));
    vecs.push_back(mk(0, 0, LW, 0, E_MR));
    vecs.push_back(mk(0, 0, LW, 1, E_MR));
    vecs.push_back(mk(0, 0, LW, 1, E_MWB));
    // undefined opcode traps; stays trapped for 10 cycles whatever op does
    vecs.push_back(mk(0, 0, BAD, 1, E_FR));
    vecs.push_back(mk(0, 0, BAD, 1, E_DEC));
    for (int i = 0; i < 10; i++)
      vecs.push_back(mk(0, 0, (i % 2 == 0) ? LW : RT, i[0], E_TRAP));
    vecs.push_back(mk(0, 1, RT, 1, E_ZERO));
    vecs.push_back(mk(0, 0, RT, 1, E_FR));
    // dut_b: mem_ready ignored, bne is illegal
    vecs.push_back(mk(1, 1, RT, 0, E_ZERO));
    vecs.push_back(mk(1, 0, LW, 0, E_FR));
    vecs.push_back(mk(1, 0, LW, 0, E_DEC));
    vecs.push_back(mk(1, 0, LW, 0, E_MA));
    vecs.push_back(mk(1, 0, LW, 0, E_MR));
    vecs.push_back(mk(1, 0, LW, 0, E_MWB));
    vecs.push_back(mk(1, 0, BEQ, 0, E_FR));
    vecs.push_back(mk(1, 0, BEQ, 0, E_DEC));
    vecs.push_back(mk(1, 0, BEQ, 0, E_BEQ));
    vecs.push_back(mk(1, 0, BNE, 1, E_FR));
    vecs.push_back(mk(1, 0, BNE, 1, E_DEC));
    vecs.push_back(mk(1, 0, BNE, 1, E_TRAP));
    vecs.push_back(mk(1, 0, BEQ, 1, E_TRAP));
    vecs.push_back(mk(1, 1, BEQ, 1, E_ZERO));

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

    // Reset asserted mid-MEMREAD, between clock edges.
    @(negedge clk); a_rst = 1'b1; a_op = LW; a_rdy = 1'b1;
    #1 check("mr_pre_reset", a_out, E_ZERO);
    @(negedge clk); a_rst = 1'b0;
    #1 check("mr_fetch", a_out, E_FR);
    @(negedge clk); #1 check("mr_decode", a_out, E_DEC);
    @(negedge clk); #1 check("mr_memadr", a_out, E_MA);
    @(negedge clk); a_rdy = 1'b0;
    #1 check("mr_memread", a_out, E_MR);
    @(posedge clk); #2 check("mr_memread_hold", a_out, E_MR);
    a_rst = 1'b1;
    #1 check("mr_reset_immediate", a_out, E_ZERO);
    @(negedge clk); a_rst = 1'b0; a_rdy = 1'b1; a_op = RT;
    #1 check("mr_refetch", a_out, E_FR);
    @(negedge clk); #1 check("mr_redecode", a_out, E_DEC);

    // sw stall: memwrite must be high for exactly 4 consecutive cycles.
    @(negedge clk); a_rst = 1'b1;
    @(negedge clk); a_rst = 1'b0; a_op = SW; a_rdy = 1'b1;
    @(negedge clk);
    @(negedge clk);
    mw_cnt = 0;
    rw_seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      a_rdy = (mw_cnt == 3);
      #1;
      if (a_regwrite) rw_seen = 1'b1;
      if (!a_memwrite) break;
      mw_cnt++;
    end
    check("sw_memwrite_cycles", 17'(mw_cnt), 17'd4);
    check("sw_back_to_fetch", a_out, E_FW);
    check("sw_no_regwrite", {16'd0, rw_seen}, 17'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/mips_multicycle_controller.md
# mips_multicycle_controller

Control FSM for the multicycle MIPS datapath. It replaces the single-cycle opcode decoder with a Moore state machine that sequences each instruction through fetch, decode, execute, memory and writeback. It handles lw, sw, R-type, beq, addi and j, plus an optional bne. It stretches memory states through a ready handshake and traps undefined opcodes. It sits between the instruction register opcode field and the shared-memory multicycle datapath; the ALU decoder stays external and consumes `aluop`.

## Interface
- `OP_W`, 6: opcode field width.
- `SUPPORT_BNE`, 0: when 1, opcode 000101 is legal and branches on `!zero`.
- `MEM_WAIT`, 1: when 1, the memory states wait for `mem_ready`; when 0, `mem_ready` is ignored and treated as 1.
- `clk`  in  1: rising-edge clock.
- `reset`  in  1: asynchronous, active-high; forces state FETCH.
- `op`  in  OP_W: opcode from the instruction register, sampled in DECODE.
- `mem_ready`  in  1: memory access completes this cycle.
- `iord`  out  1: memory address select (0 = PC, 1 = ALUOut).
- `memwrite`  out  1: memory write strobe.
- `irwrite`  out  1: instruction register load.
- `pcwrite`  out  1: unconditional PC load.
- `branch`  out  1: PC load if `zero` (beq).
- `branch_ne`  out  1: PC load if `!zero` (bne; tied 0 when SUPPORT_BNE=0).
- `pcsrc`  out  2: PC source (00 = ALU, 01 = ALUOut, 10 = jump target).
- `alusrca`  out  1: ALU A select (0 = PC, 1 = register A).
- `alusrcb`  out  2: ALU B select (00 = B, 01 = 4, 10 = SignImm, 11 = SignImm<<2).
- `aluop`  out  2: 00 = add, 01 = subtract, 10 = use funct.
- `regwrite`  out  1: register file write enable.
- `memtoreg`  out  1: write-data select (1 = Data register).
- `regdst`  out  1: destination select (1 = rd).
- `illegal_op`  out  1: sticky trap flag.

## Operation
- States are 4-bit: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11, TRAP=12. Codes 13–15 go to FETCH.
- Outputs are Moore. Any output not listed for a state is 0.
- FETCH: `alusrcb`=01, `irwrite`=`pcwrite`=`mem_ready`. Stays in FETCH while `!mem_ready`, otherwise goes to DECODE.
- DECODE: `alusrcb`=11. Next state by opcode:
  - lw/sw → MEMADR
  - R-type (000000) → EXECUTE
  - beq, or bne when enabled → BRANCH
  - addi → ADDIEX
  - j → JUMP
  - anything else → TRAP
- MEMADR: `alusrca`=1, `alusrcb`=10. Goes to MEMREAD for lw, MEMWRITE for sw; the opcode is held stable by the IR.
- MEMREAD: `iord`=1. Waits for `mem_ready`, then goes to MEMWB.
- MEMWB: `regwrite`=1, `memtoreg`=1. Goes to FETCH.
- MEMWRITE: `iord`=1, `memwrite`=1, held until `mem_ready`. Goes to FETCH.
- EXECUTE: `alusrca`=1, `aluop`=10. Goes to ALUWB.
- ALUWB: `regdst`=1, `regwrite`=1. Goes to FETCH.
- BRANCH: `alusrca`=1, `aluop`=01, `pcsrc`=01. Asserts `branch` for beq or `branch_ne` for bne. Goes to FETCH.
- ADDIEX: `alusrca`=1, `alusrcb`=10. Goes to ADDIWB.
- ADDIWB: `regwrite`=1. Goes to FETCH.
- JUMP: `pcsrc`=10, `pcwrite`=1. Goes to FETCH.
- TRAP: `illegal_op`=1, all write enables 0. Exits only on reset.
- With SUPPORT_BNE=0, opcode 000101 goes to TRAP.

## Timing
- Reset asserted: state=FETCH and every output is 0, including `irwrite` and `pcwrite`, which are gated by `!reset`.
- Reset takes effect immediately, mid-instruction included. The next fetch starts on the first rising edge after deassertion.
- Cycles per instruction with zero memory wait: lw 5, sw 4, R-type 4, addi 4, beq/bne 3, j 3.
- Each wait cycle with `mem_ready`=0 in FETCH, MEMREAD or MEMWRITE adds one cycle.
- `memwrite` stays high for the whole stall, so the slave samples it on the `mem_ready` cycle.
- `irwrite`/`pcwrite` in FETCH pulse for exactly one cycle: the `mem_ready` cycle.
- `op` is sampled only in DECODE and MEMADR; changes in other states are ignored.

## Structure
- Shared package `mips_pkg` holds:
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_J)
  - state encodings
  - ALUOp, PCSrc and ALUSrcB codes
- One sub-module is natural: `mc_output_decode`, a purely combinational state→control-word lookup. The FSM module holds the state register and next-state logic.

## Test plan
- lw with `mem_ready` tied 1: states 0,1,2,3,4,0 over 5 cycles; `regwrite`&`memtoreg` high only in cycle 5; `irwrite` high only in cycle 1.
- sw with `mem_ready` low for 3 cycles in MEMWRITE: `memwrite` high for 4 consecutive cycles; state returns to FETCH after the ready cycle; `regwrite` never asserts.
- beq, then bne with SUPPORT_BNE=1: `branch`=1 then `branch_ne`=1 in the BRANCH cycle, with `aluop`=01 and `pcsrc`=01. Same bne with SUPPORT_BNE=0 → `illegal_op`=1.
- j: JUMP cycle has `pcsrc`=10 and `pcwrite`=1; total 3 cycles.
- Opcode 111111 → TRAP; `illegal_op` stays 1 for 10 cycles regardless of `op`; reset clears it and state goes to FETCH.
- Reset asserted during MEMREAD, between clock edges: outputs drop to 0 immediately; after release, FETCH fetches with `iord`=0 and `alusrcb`=01.
